mux_arb_reg: RTL and testbench

- Parametrised successor to the team's fixed 8:1 byte multiplexer.
- Selects one of N_IN valid/ready input channels of WIDTH bits and forwards it through a single registered output stage.
- Channel choice is either a software-driven select (fixed mode) or fair round-robin arbitration.
- Sits between the ALU/RAM result producers and the shared write-back/result bus.

---
 rtl/mux_arb_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/mux_arb_reg.sv | 99 +++++++++
 tb/tb_mux_arb_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and index arithmetic for the result-bus multiplexer
//
// Purpose : channel-selection mode encoding and the rotate-and-priority-encode
//           helper used by the round-robin arbiter.
// Contents: mux_mode_t, MAX_IN, rr_pick()
package mux_arb_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  // Widest channel count the helper is written for (4-bit index).
  localparam int MAX_IN = 16;

  // Returns {found, idx}: the first set bit of req[n-1:0] when searching
  // upward from (ptr+1) mod n with wrap-around.  The loop runs from the
  // farthest candidate to the nearest so the nearest one is written last.
  function automatic logic [4:0] rr_pick(input logic [MAX_IN-1:0] req,
                                         input logic [3:0]        ptr,
                                         input int                n);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = MAX_IN; k >= 1; k--) begin
      if (k <= n) begin
        idx = 4'((int'(ptr) + k) % n);
        if (req[idx]) res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose : grants the first requesting channel after the last-served one.
// Ports   : req       [N_IN]  per-channel request
//           ptr       [SEL_W] index of the last-served channel
//           grant     [N_IN]  one-hot grant (zero when nothing requests)
//           grant_idx [SEL_W] index of the granted channel
//           any_grant         a channel is granted
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_IN  = 8,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [4:0] pick;

  assign pick      = rr_pick(MAX_IN'(req), 4'(ptr), N_IN);
  assign any_grant = pick[4];
  assign grant_idx = SEL_W'(pick[3:0]);

  always_comb begin
    grant = '0;
    for (int i = 0; i < N_IN; i++) begin
      grant[i] = any_grant && (grant_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - N-input valid/ready multiplexer with registered output
//
// Purpose : forwards one of N_IN channels to a single registered output,
//           chosen by software select (fixed) or round-robin arbitration.
// Ports   : clk, rst_n           clock, asynchronous active-low reset
//           in_data  [N_IN*WIDTH] packed channel data, channel i at [i*WIDTH +: WIDTH]
//           in_valid [N_IN]       per-channel valid
//           in_ready [N_IN]       per-channel ready, one-hot or zero
//           mode                  0 fixed select, 1 round-robin
//           sel      [SEL_W]      channel used in fixed mode
//           out_data [WIDTH]      registered word
//           out_valid             out_data holds a word
//           out_ready             downstream accepts the word
//           out_src  [SEL_W]      channel that produced out_data
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N_IN  = 8,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_src
);

  logic [SEL_W-1:0] rr_ptr;
  logic [N_IN-1:0]  rr_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [N_IN-1:0]  fix_grant;
  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] win_src;
  logic             win_any;
  logic [WIDTH-1:0] win_data;
  logic             is_rr;
  logic             load;
  logic             xfer;

  rr_arbiter #(.N_IN(N_IN)) u_rr (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_grant (rr_any)
  );

  // A sel value at or beyond N_IN matches no channel, so it grants nothing.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < N_IN; i++) begin
      fix_grant[i] = in_valid[i] && (sel == SEL_W'(i));
    end
  end

  assign is_rr   = (mux_mode_t'(mode) == MODE_RR);
  assign grant   = is_rr ? rr_grant : fix_grant;
  assign win_src = is_rr ? rr_idx   : sel;
  assign win_any = is_rr ? rr_any   : |fix_grant;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) win_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // The register can take a word when empty or when its current word drains.
  assign load = !out_valid || out_ready;
  assign xfer = load && win_any;

  // Gated by rst_n so no source sees a handshake while the block is held in reset.
  assign in_ready = (rst_n && load) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SEL_W'(N_IN - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_src   <= win_src;
      if (is_rr) rr_ptr <= win_src;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - scoreboard bench for mux_arb_reg
module tb_mux_arb_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_src;

  logic [47:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_ready6;
  logic        mode6;
  logic [2:0]  sel6;
  logic [7:0]  out_data6;
  logic        out_valid6;
  logic        out_ready6;
  logic [2:0]  out_src6;

  int          vectors = 0;
  int          miscompares = 0;
  logic [10:0] sb[$];
  logic [10:0] head;

  always #5 clk = ~clk;

  mux_arb_reg #(.WIDTH(8), .N_IN(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
  );

  mux_arb_reg #(.WIDTH(8), .N_IN(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .mode(mode6), .sel(sel6), .out_data(out_data6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_src(out_src6)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks in_ready for the inputs just driven, records the word the
  // upcoming edge should capture, then advances one cycle.
  task automatic cyc(input logic [7:0] exp_rdy, input bit push,
                     input logic [2:0] src, input logic [7:0] d);
    #1;
    chk("in_ready", in_ready, exp_rdy);
    if (push) sb.push_back({src, d});
    @(posedge clk);
    #1;
  endtask

  // Monitor: a word is consumed at the edge following a negedge where
  // out_valid && out_ready, so each accepted word is popped exactly once.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: got src %0d data %0h expected no word", out_src, out_data);
      end else begin
        head = sb.pop_front();
        chk("sb_data", out_data, head[7:0]);
        chk("sb_src", out_src, head[10:8]);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    in_data    = {8'h78, 8'h69, 8'hA5, 8'h4B, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
    in_valid   = 8'hFF;
    mode       = 1'b0;
    sel        = 3'd0;
    out_ready  = 1'b1;
    in_data6   = {8'h5A, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    in_valid6  = 6'h00;
    mode6      = 1'b0;
    sel6       = 3'd0;
    out_ready6 = 1'b1;

    // Reset state with every channel requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_in_ready", in_ready, 0);

    // First round-robin search after reset starts at channel 0.
    mode  = 1'b1;
    rst_n = 1'b1;
    cyc(8'h01, 1, 3'd0, 8'h0F);

    // Round-robin fairness over channels 1, 3, 7.
    in_valid = 8'b1000_1010;
    for (int r = 0; r < 2; r++) begin
      cyc(8'h02, 1, 3'd1, 8'h1E);
      cyc(8'h08, 1, 3'd3, 8'h3C);
      cyc(8'h80, 1, 3'd7, 8'h78);
    end
    in_valid = 8'h00;
    cyc(8'h00, 0, 3'd0, 8'h00);
    chk("rr_drain_valid", out_valid, 0);

    // Fixed mode, sel=5, every channel valid.
    mode     = 1'b0;
    sel      = 3'd5;
    in_valid = 8'hFF;
    repeat (3) cyc(8'h20, 1, 3'd5, 8'hA5);
    in_valid = 8'h00;
    cyc(8'h00, 0, 3'd0, 8'h00);
    chk("fix_drain_valid", out_valid, 0);

    // Six-channel instance: in-range then out-of-range select.
    sel6      = 3'd5;
    in_valid6 = 6'h3F;
    #1;
    chk("n6_in_ready_sel5", in_ready6, 6'h20);
    @(posedge clk);
    #1;
    chk("n6_out_valid", out_valid6, 1);
    chk("n6_out_data", out_data6, 8'h5A);
    chk("n6_out_src", out_src6, 5);
    sel6 = 3'd7;
    #1;
    chk("n6_in_ready_sel7", in_ready6, 0);
    @(posedge clk);
    #1;
    chk("n6_drained_valid", out_valid6, 0);
    chk("n6_in_ready_idle", in_ready6, 0);
    in_valid6 = 6'h00;

    // Backpressure: hold 8'h3C while channel 2 waits.
    sel      = 3'd3;
    in_valid = 8'h08;
    cyc(8'h08, 1, 3'd3, 8'h3C);
    sel       = 3'd2;
    in_valid  = 8'h04;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(8'h00, 0, 3'd0, 8'h00);
      chk("bp_out_data", out_data, 8'h3C);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    cyc(8'h04, 1, 3'd2, 8'h2D);
    in_valid = 8'h00;
    cyc(8'h00, 0, 3'd0, 8'h00);

    // Mid-operation reset with a word held; rr_ptr would otherwise be 1.
    mode     = 1'b1;
    in_valid = 8'h02;
    cyc(8'h02, 1, 3'd1, 8'h1E);
    out_ready = 1'b0;
    in_valid  = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 8'h11;
    cyc(8'h01, 1, 3'd0, 8'h0F);
    in_valid = 8'h00;
    repeat (3) cyc(8'h00, 0, 3'd0, 8'h00);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
